// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter generator.
//   XLEN_DEFAULT         : default PC/address width
//   RESET_VECTOR_DEFAULT : default PC loaded on reset
//   INSN_STEP            : sequential fetch increment in bytes
//   pc_src_e             : which source feeds the next PC
package pc_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned INSN_STEP            = 4;

    typedef enum logic [2:0] {
        PC_TRAP,
        PC_REDIRECT,
        PC_RAS,
        PC_SEQ,
        PC_HOLD
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk, reset  : clock, async active-high reset
//   push, pop   : already qualified push/pop requests
//   flush       : discard all entries (wins over push/pop)
//   push_addr   : return address written on push
//   top_addr_c  : combinational read of the current top entry
//   empty, full : registered occupancy flags
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top_addr_c,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             mem_we;
    logic [PTR_W-1:0] mem_widx;

    // Pointer/count update; full stack overwrites the oldest slot by wrapping.
    always_comb begin
        top_d    = top_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        mem_widx = top_q;
        if (flush) begin
            top_d   = '0;
            count_d = '0;
        end else if (push && pop && !empty_q) begin
            // Pop then push: replace the top in place.
            mem_we   = 1'b1;
            mem_widx = top_q;
        end else if (push) begin
            top_d    = top_q + PTR_W'(1);
            mem_we   = 1'b1;
            mem_widx = top_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty_q) begin
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Storage is not reset; entries are invisible while the count is zero.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= push_addr;
        end
    end

    assign top_addr_c = mem_q[top_q];
    assign empty      = empty_q;
    assign full       = full_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap/redirect override and a
// return-address stack for predicted returns.
//   clk, reset        : clock, async active-high reset
//   pc_en             : advance enable (low = stall)
//   redirect_valid/_target : resolved taken branch/jump
//   trap_valid/trap_vector : trap entry, also flushes the RAS
//   ras_push/_addr    : call detected, push return address
//   ras_pop           : return predicted, next pc from RAS top
//   pc                : registered fetch PC
//   pc_next           : combinational value pc takes at the next edge
//   misaligned        : registered, last trap/redirect target had bits[1:0] != 0
//   ras_empty/ras_full: RAS occupancy flags
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] ras_top;
    logic            seq_ok;
    pc_src_e         src;

    // RAS only moves on an unredirected, enabled fetch; trap flushes it.
    assign seq_ok = pc_en && !trap_valid && !redirect_valid;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .reset      (reset),
        .push       (seq_ok && ras_push),
        .pop        (seq_ok && ras_pop),
        .flush      (trap_valid),
        .push_addr  (ras_push_addr),
        .top_addr_c (ras_top),
        .empty      (ras_empty),
        .full       (ras_full)
    );

    // Source select and next-pc mux; control-flow targets are word-aligned.
    always_comb begin
        src          = PC_HOLD;
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (trap_valid) begin
            src = PC_TRAP;
        end else if (redirect_valid) begin
            src = PC_REDIRECT;
        end else if (pc_en && ras_pop && !ras_empty) begin
            src = PC_RAS;
        end else if (pc_en) begin
            src = PC_SEQ;
        end
        unique case (src)
            PC_TRAP: begin
                pc_d         = {trap_vector[XLEN-1:2], 2'b00};
                misaligned_d = (trap_vector[1:0] != 2'b00);
            end
            PC_REDIRECT: begin
                pc_d         = {redirect_target[XLEN-1:2], 2'b00};
                misaligned_d = (redirect_target[1:0] != 2'b00);
            end
            PC_RAS:  pc_d = ras_top;
            PC_SEQ:  pc_d = pc_q + XLEN'(INSN_STEP);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign pc_next    = pc_d;
    assign misaligned = misaligned_q;

endmodule
